// File: rtl/ticket_vendor_seq.sv
// Multi-channel sequential ticket vending engine: coin credit, per-channel price/stock
// tables, W-cycle restoring divide. Optional per-request ticket cap under TICKET_LIMIT_EN.
module ticket_vendor_seq #(
  parameter int W   = 8,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_price,
  input  logic [W-1:0]  cfg_stock,
  input  logic          coin_valid,
  input  logic [W-1:0]  coin_amt,
  input  logic          cancel,
  input  logic          req_valid,
  input  logic [CW-1:0] req_ch,
`ifdef TICKET_LIMIT_EN
  input  logic [W-1:0]  max_tix,
`endif
  output logic          req_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_ticket,
  output logic [W-1:0]  out_change,
  output logic          out_err,
  output logic          busy,
  output logic [W-1:0]  credit
);

  localparam int CNTW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, DIV, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    credit_q, credit_d;
  logic [W-1:0]    price_q [NCH];
  logic [W-1:0]    stock_q [NCH];

  // Transaction snapshot
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    p_q, p_d;
  logic [W-1:0]    s_q, s_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [W-1:0]    lim_q, lim_d;

  // Divider and result registers
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    t_q, t_d;
  logic [W-1:0]    c_q, c_d;

  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic [W-1:0]    out_ticket_q, out_ticket_d;
  logic [W-1:0]    out_change_q, out_change_d;
  logic            out_err_q, out_err_d;

  logic [W:0]      coin_sum;
  logic [W-1:0]    credit_in;
  logic            accept;
  logic            cfg_en;
  logic            stk_we;
  logic [W:0]      rem_sh;
  logic            ge;
  logic [W-1:0]    t_calc;
  logic [2*W-1:0]  prod;

  assign req_ready  = (state_q == IDLE) && !cancel;
  assign busy       = (state_q != IDLE);
  assign credit     = credit_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_ticket = out_ticket_q;
  assign out_change = out_change_q;
  assign out_err    = out_err_q;

  assign accept = (state_q == IDLE) && req_valid && !cancel;
  assign cfg_en = cfg_we && (state_q == IDLE) && !accept;
  assign stk_we = (state_q == DONE);

  // Saturating credit plus this cycle's coin
  always_comb begin
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
    credit_in = credit_q;
    if (coin_valid) credit_in = coin_sum[W] ? '1 : coin_sum[W-1:0];
  end

  always_comb begin
    rem_sh = {rem_q[W-1:0], quo_q[W-1]};
    ge     = (rem_sh >= {1'b0, p_q});
    t_calc = (quo_q < s_q) ? quo_q : s_q;
`ifdef TICKET_LIMIT_EN
    if ((lim_q != '0) && (lim_q < t_calc)) t_calc = lim_q;
`endif
    if ((p_q == '0) || (s_q == '0)) t_calc = '0;
    prod = {{W{1'b0}}, t_calc} * {{W{1'b0}}, p_q};
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_in;
    d_d          = d_q;
    p_d          = p_q;
    s_d          = s_q;
    ch_d         = ch_q;
    lim_d        = lim_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    t_d          = t_q;
    c_d          = c_q;
    out_valid_d  = 1'b0;
    out_ch_d     = out_ch_q;
    out_ticket_d = out_ticket_q;
    out_change_d = out_change_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          out_valid_d  = 1'b1;
          out_ticket_d = '0;
          out_change_d = credit_in;
          out_err_d    = 1'b0;
          credit_d     = '0;
        end else if (accept) begin
          d_d      = credit_in;
          p_d      = price_q[req_ch];
          s_d      = stock_q[req_ch];
          ch_d     = req_ch;
`ifdef TICKET_LIMIT_EN
          lim_d    = max_tix;
`else
          lim_d    = '0;
`endif
          credit_d = '0;
          rem_d    = '0;
          quo_d    = credit_in;
          cnt_d    = '0;
          if ((price_q[req_ch] == '0) || (stock_q[req_ch] == '0)) state_d = CALC;
          else                                                   state_d = DIV;
        end
      end
      DIV: begin
        rem_d = ge ? (rem_sh - {1'b0, p_q}) : rem_sh;
        quo_d = {quo_q[W-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(W - 1)) state_d = CALC;
      end
      CALC: begin
        t_d     = t_calc;
        c_d     = d_q - prod[W-1:0];
        state_d = DONE;
      end
      DONE: begin
        out_valid_d  = 1'b1;
        out_ticket_d = t_q;
        out_change_d = c_q;
        out_ch_d     = ch_q;
        out_err_d    = (p_q == '0);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      d_q          <= '0;
      p_q          <= '0;
      s_q          <= '0;
      ch_q         <= '0;
      lim_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      t_q          <= '0;
      c_q          <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_ticket_q <= '0;
      out_change_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      d_q          <= d_d;
      p_q          <= p_d;
      s_q          <= s_d;
      ch_q         <= ch_d;
      lim_q        <= lim_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      c_q          <= c_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_ticket_q <= out_ticket_d;
      out_change_q <= out_change_d;
      out_err_q    <= out_err_d;
    end
  end

  // Config writes and stock decrement never coincide: one needs IDLE, the other DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else if (cfg_en) begin
      price_q[cfg_ch] <= cfg_price;
      stock_q[cfg_ch] <= cfg_stock;
    end else if (stk_we) begin
      stock_q[ch_q] <= stock_q[ch_q] - t_q;
    end
  end

endmodule

// File: tb/tb_ticket_vendor_seq.sv
// Scoreboard bench for ticket_vendor_seq: directed purchases push expected results,
// a negedge monitor pops and compares each out_valid pulse including its arrival cycle.
module tb_ticket_vendor_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_price, cfg_stock;
  logic       coin_valid;
  logic [7:0] coin_amt;
  logic       cancel;
  logic       req_valid;
  logic [1:0] req_ch;
  logic       req_ready, out_valid, out_err, busy;
  logic [1:0] out_ch;
  logic [7:0] out_ticket, out_change, credit;
`ifdef TICKET_LIMIT_EN
  logic [7:0] max_tix;
`endif

  ticket_vendor_seq #(.W(8), .NCH(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_price(cfg_price),
    .cfg_stock(cfg_stock), .coin_valid(coin_valid), .coin_amt(coin_amt), .cancel(cancel),
    .req_valid(req_valid), .req_ch(req_ch),
`ifdef TICKET_LIMIT_EN
    .max_tix(max_tix),
`endif
    .req_ready(req_ready), .out_valid(out_valid), .out_ch(out_ch), .out_ticket(out_ticket),
    .out_change(out_change), .out_err(out_err), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit chk_ch;
    int t;
    int c;
    int e;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_ticket", int'(out_ticket), e.t);
        chk("out_change", int'(out_change), e.c);
        chk("out_err", int'(out_err), e.e);
        if (e.chk_ch) chk("out_ch", int'(out_ch), e.ch);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() > 0; i++) nxt();
    chk("pending_results", q.size(), 0);
    q.delete();
    nxt();
  endtask

  task automatic cfg(input int ch, input int price, input int stock);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_price = 8'(price); cfg_stock = 8'(stock);
    nxt();
    cfg_we = 1'b0;
  endtask

  task automatic coin(input int amt);
    coin_valid = 1'b1; coin_amt = 8'(amt);
    nxt();
    coin_valid = 1'b0;
  endtask

  task automatic buy(input int ch, input int cn, input int et, input int ec,
                     input int ee, input int lat);
    exp_t e;
    req_valid = 1'b1; req_ch = 2'(ch);
    if (cn > 0) begin coin_valid = 1'b1; coin_amt = 8'(cn); end
    chk("req_ready", int'(req_ready), 1);
    nxt();
    e.ch = ch; e.chk_ch = 1'b1; e.t = et; e.c = ec; e.e = ee; e.cyc = cyc + lat;
    q.push_back(e);
    req_valid = 1'b0; coin_valid = 1'b0;
  endtask

  task automatic do_cancel(input int ec);
    exp_t e;
    cancel = 1'b1;
    nxt();
    e.ch = 0; e.chk_ch = 1'b0; e.t = 0; e.c = ec; e.e = 0; e.cyc = cyc;
    q.push_back(e);
    cancel = 1'b0;
    wait_done();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_price = '0; cfg_stock = '0;
    coin_valid = 1'b0; coin_amt = '0; cancel = 1'b0; req_valid = 1'b0; req_ch = '0;
`ifdef TICKET_LIMIT_EN
    max_tix = '0;
`endif
    nxt(); nxt();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_out_change", int'(out_change), 0);

    // Basic purchase with remainder
    cfg(0, 3, 114);
    coin(4);
    chk("credit_after_coin", int'(credit), 4);
    buy(0, 0, 1, 1, 0, 10);
    chk("credit_cleared_on_accept", int'(credit), 0);
    wait_done();

    cfg(1, 12, 200);
    coin(20);
    buy(1, 0, 1, 8, 0, 10);   wait_done();
    coin(6);
    buy(1, 0, 0, 6, 0, 10);   wait_done();
    buy(1, 0, 0, 0, 0, 10);   wait_done();

    // Stock clamp, then empty stock short path with same-cycle coin
    cfg(2, 10, 5);
    coin(100); coin(100);
    buy(2, 0, 5, 150, 0, 10); wait_done();
    buy(2, 50, 0, 50, 0, 2);  wait_done();
    chk("credit_coin_into_snapshot", int'(credit), 0);

    // Saturation and cancel
    coin(200); coin(100);
    chk("credit_saturated", int'(credit), 255);
    do_cancel(255);
    chk("credit_after_cancel", int'(credit), 0);

    cfg(3, 0, 9);
    coin(33);
    buy(3, 0, 0, 33, 1, 2);   wait_done();

    // Coin and config write during DIV
    coin(25);
    buy(0, 0, 8, 1, 0, 10);
    chk("busy_in_div", int'(busy), 1);
    chk("req_ready_busy", int'(req_ready), 0);
    coin_valid = 1'b1; coin_amt = 8'd7;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_price = 8'd1; cfg_stock = 8'd1;
    nxt();
    coin_valid = 1'b0; cfg_we = 1'b0;
    wait_done();
    chk("credit_coin_during_busy", int'(credit), 7);
    do_cancel(7);
    coin(7);
    buy(0, 0, 2, 1, 0, 10);   wait_done();

    // Reset in the middle of DIV discards the transaction
    coin(20);
    req_valid = 1'b1; req_ch = 2'd1;
    nxt();
    req_valid = 1'b0;
    nxt(); nxt(); nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_ticket", int'(out_ticket), 0);
    chk("midrst_out_change", int'(out_change), 0);
    chk("midrst_out_ch", int'(out_ch), 0);
    chk("midrst_credit", int'(credit), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    for (int i = 0; i < 14; i++) nxt();
    buy(0, 5, 0, 5, 1, 2);    wait_done();

`ifdef TICKET_LIMIT_EN
    cfg(0, 3, 50);
    coin(20);
    max_tix = 8'd2;
    buy(0, 0, 2, 14, 0, 10);  wait_done();
    max_tix = 8'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
